// File: rtl/myproject_acc_pkg.sv
// Shared definitions for the accumulate-and-requantize block.
// Holds the default word widths, the default fractional shift and the
// encoding of the two-state control FSM.
package myproject_acc_pkg;

    localparam int DIN_WIDTH_DEF  = 26;
    localparam int ACC_WIDTH_DEF  = 32;
    localparam int DOUT_WIDTH_DEF = 16;
    localparam int FRAC_SHIFT_DEF = 10;

    // ST_ACC : collecting product terms
    // ST_HOLD: presenting a finished result downstream
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } acc_state_t;

endpackage

// File: rtl/myproject_acc_requant_sat.sv
// Combinational requantizer: round-half-up and clip an accumulator value
// down to the output word.
// Ports:
//   acc_in : signed accumulator value (ACC_WIDTH bits)
//   q      : rounded, clipped result (DOUT_WIDTH bits, signed)
//   clip   : 1 when the rounded value fell outside the output range
module myproject_acc_requant_sat
    import myproject_acc_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_in,
    output logic signed [DOUT_WIDTH-1:0] q,
    output logic                         clip
);

    // One extra bit of headroom so adding the half-LSB can never wrap.
    localparam logic signed [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH+1)'(1) << (FRAC_SHIFT-1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX  =
        {{(ACC_WIDTH+2-DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN  =
        {{(ACC_WIDTH+2-DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] shr;

    always_comb begin
        rnd  = {acc_in[ACC_WIDTH-1], acc_in} + RND_HALF;
        shr  = rnd >>> FRAC_SHIFT;
        q    = shr[DOUT_WIDTH-1:0];
        clip = 1'b0;
        if (shr > OUT_MAX) begin
            q    = OUT_MAX[DOUT_WIDTH-1:0];
            clip = 1'b1;
        end else if (shr < OUT_MIN) begin
            q    = OUT_MIN[DOUT_WIDTH-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/myproject_acc_requant.sv
// Dot-product accumulator with saturating add and requantized output.
// Terms stream in on din; the term flagged din_last closes the vector and
// its rounded/clipped sum is held on dout until downstream takes it.
// Ports:
//   ap_clk, ap_rst        : clock, asynchronous active-high reset
//   din/din_vld/din_last  : signed product term, valid, end-of-vector
//   din_rdy               : term accepted on this cycle's rising edge
//   dout/dout_vld/dout_ovf: result, valid, sticky overflow (acc or output)
//   dout_rdy              : downstream accepts dout
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid never depends on ready. din_rdy is 1 only while collecting
// terms; dout_vld is 1 only while holding a result, and dout/dout_ovf stay
// frozen until the edge that completes the output transfer.
module myproject_acc_requant
    import myproject_acc_pkg::*;
#(
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [DIN_WIDTH-1:0]         din,
    input  logic                         din_vld,
    input  logic                         din_last,
    output logic                         din_rdy,
    output logic [DOUT_WIDTH-1:0]        dout,
    output logic                         dout_vld,
    input  logic                         dout_rdy,
    output logic                         dout_ovf
);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    acc_state_t                  state, state_nxt;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_sat;
    logic signed [ACC_WIDTH:0]   sum_wide;
    logic                        acc_clip;
    logic                        ovf;
    logic                        accept;
    logic                        unload;
    logic signed [DOUT_WIDTH-1:0] q;
    logic                        q_clip;

    // Saturating add: sum in ACC_WIDTH+1 bits, the two top bits disagree
    // exactly when the true sum is outside the accumulator range.
    always_comb begin
        sum_wide = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH+1-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
        acc_clip = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        if (acc_clip)
            acc_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else
            acc_sat = sum_wide[ACC_WIDTH-1:0];
    end

    myproject_acc_requant_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .DOUT_WIDTH(DOUT_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_sat (
        .acc_in(acc_sat),
        .q     (q),
        .clip  (q_clip)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= ST_ACC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        din_rdy   = 1'b0;
        dout_vld  = 1'b0;
        accept    = 1'b0;
        unload    = 1'b0;
        case (state)
            ST_ACC: begin
                din_rdy = 1'b1;
                accept  = din_vld;
                if (din_vld && din_last) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                dout_vld = 1'b1;
                unload   = dout_rdy;
                if (dout_rdy) state_nxt = ST_ACC;
            end
            default: state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            acc      <= '0;
            ovf      <= 1'b0;
            dout     <= '0;
            dout_ovf <= 1'b0;
        end else begin
            if (accept) begin
                ovf <= ovf | acc_clip;
                if (din_last) begin
                    // The closing term is folded in before requantizing.
                    dout     <= q;
                    dout_ovf <= ovf | acc_clip | q_clip;
                    acc      <= '0;
                end else begin
                    acc <= acc_sat;
                end
            end
            if (unload) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_myproject_acc_requant.sv
module tb_myproject_acc_requant;

    localparam int DW = 26;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int FS = 10;
    localparam longint ACC_MAX = (64'sd1 <<< (AW-1)) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< (AW-1));
    localparam longint OUT_MAX = (64'sd1 <<< (OW-1)) - 1;
    localparam longint OUT_MIN = -(64'sd1 <<< (OW-1));

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [DW-1:0] din;
    logic          din_vld;
    logic          din_last;
    logic          din_rdy;
    logic [OW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy;
    logic          dout_ovf;

    int tests = 0;
    int fails = 0;
    bit run_cmp = 1'b0;

    // Scoreboard: {ovf, dout} of every result the model expects to be shown.
    logic [OW:0] exp_q[$];
    bit          m_hold;
    longint      m_acc;
    bit          m_ovf;

    myproject_acc_requant dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .din     (din),
        .din_vld (din_vld),
        .din_last(din_last),
        .din_rdy (din_rdy),
        .dout    (dout),
        .dout_vld(dout_vld),
        .dout_rdy(dout_rdy),
        .dout_ovf(dout_ovf)
    );

    // ---------------- clock / reset ----------------
    always #5 ap_clk = ~ap_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works on the bench's own stimulus: integer sum, clamp, round, clamp.
    initial begin
        longint s;
        longint r;
        bit     c;
        forever begin
            @(posedge ap_clk or posedge ap_rst);
            if (ap_rst) begin
                m_hold = 1'b0;
                m_acc  = 0;
                m_ovf  = 1'b0;
                exp_q.delete();
            end else if (!m_hold) begin
                if (din_vld) begin
                    s = m_acc + longint'($signed(din));
                    c = 1'b0;
                    if (s > ACC_MAX) begin s = ACC_MAX; c = 1'b1; end
                    else if (s < ACC_MIN) begin s = ACC_MIN; c = 1'b1; end
                    m_ovf = m_ovf | c;
                    if (din_last) begin
                        r = (s + (64'sd1 <<< (FS-1))) >>> FS;
                        c = 1'b0;
                        if (r > OUT_MAX) begin r = OUT_MAX; c = 1'b1; end
                        else if (r < OUT_MIN) begin r = OUT_MIN; c = 1'b1; end
                        exp_q.push_back({m_ovf | c, r[OW-1:0]});
                        m_hold = 1'b1;
                        m_acc  = 0;
                    end else begin
                        m_acc = s;
                    end
                end
            end else if (dout_rdy) begin
                m_hold = 1'b0;
                m_ovf  = 1'b0;
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge ap_clk);
            if (run_cmp && !ap_rst) begin
                check("cmp_din_rdy", din_rdy, !m_hold);
                check("cmp_dout_vld", dout_vld, m_hold);
                if (m_hold) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL cmp_queue: model holds a result but queue is empty");
                    end else begin
                        check("cmp_dout_word", {dout_ovf, dout}, exp_q[0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 of the edge that took the term.
    task automatic drive_term(input longint v, input bit last);
        bit r;
        bit done = 1'b0;
        din      = v[DW-1:0];
        din_vld  = 1'b1;
        din_last = last;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge ap_clk);
            r = din_rdy;
            @(posedge ap_clk);
            #1;
            if (r) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drive_term: din_rdy stayed 0, required 1 within 30 cycles");
        end
        din_vld  = 1'b0;
        din_last = 1'b0;
    endtask

    // Expects the result one cycle after the last-term edge, checks it
    // against hand literals (DUT and model), then releases it.
    task automatic take_result(input string name, input longint exp_dout, input bit exp_ovf);
        bit          seen;
        logic [OW:0] e;
        @(negedge ap_clk);
        check({name, "_vld_latency"}, dout_vld, 1);
        seen = dout_vld;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge ap_clk);
            seen = dout_vld;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: dout_vld stayed 0, required 1", name);
        end else begin
            check({name, "_dout"}, longint'($signed(dout)), exp_dout);
            check({name, "_ovf"}, dout_ovf, exp_ovf);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s_model: model queue empty, required one result", name);
            end else begin
                e = exp_q[0];
                check({name, "_model_dout"}, longint'($signed(e[OW-1:0])), exp_dout);
                check({name, "_model_ovf"}, e[OW], exp_ovf);
            end
        end
        dout_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        dout_rdy = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        ap_rst   = 1'b1;
        din      = '0;
        din_vld  = 1'b0;
        din_last = 1'b0;
        dout_rdy = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        check("rst_dout", dout, 0);
        check("rst_dout_ovf", dout_ovf, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_din_rdy", din_rdy, 1);
        @(posedge ap_clk);
        #1;
        run_cmp = 1'b1;

        // 3072 + 512 = 3584 -> >>10 = 3
        drive_term(1024, 0);
        drive_term(1024, 0);
        drive_term(1024, 1);
        take_result("sum3", 3, 1'b0);

        // rounding, half toward +inf
        drive_term(512, 1);
        take_result("rnd_p512", 1, 1'b0);
        drive_term(-512, 1);
        take_result("rnd_m512", 0, 1'b0);
        drive_term(-513, 1);
        take_result("rnd_m513", -1, 1'b0);

        // 2500 + 512 = 3012 -> 2 ; -3000 + 512 = -2488 -> floor(-2.43) = -3
        drive_term(3000, 0);
        drive_term(-1000, 0);
        drive_term(500, 1);
        take_result("mix_pos", 2, 1'b0);
        drive_term(-2000, 0);
        drive_term(-1000, 1);
        take_result("mix_neg", -3, 1'b0);

        // output clip high; the most negative input rounds to exactly
        // -32768 ((-33554432+512)>>>10), which is in range, so no clip
        drive_term(33554431, 1);
        take_result("osat_hi", 32767, 1'b1);
        drive_term(-33554432, 1);
        take_result("osat_lo", -32768, 1'b0);

        // accumulator clip: 70 * 33554431 exceeds 2^31-1
        for (int i = 0; i < 69; i++) drive_term(33554431, 0);
        drive_term(33554431, 1);
        take_result("acc_sat", 32767, 1'b1);
        drive_term(1024, 1);
        take_result("after_sat", 1, 1'b0);

        // backpressure: a pending term must not be taken during HOLD
        drive_term(1024, 1);
        din      = 26'd1024;
        din_vld  = 1'b1;
        din_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            check("bp_dout", longint'($signed(dout)), 1);
            check("bp_dout_ovf", dout_ovf, 0);
            check("bp_din_rdy", din_rdy, 0);
        end
        dout_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        dout_rdy = 1'b0;
        @(negedge ap_clk);
        check("bp_resume_rdy", din_rdy, 1);
        @(posedge ap_clk);
        #1;
        din_vld = 1'b0;
        drive_term(1024, 1);
        take_result("bp_after", 2, 1'b0);

        // reset mid-vector discards the partial sum; the reset edge takes nothing
        drive_term(1024, 0);
        drive_term(1024, 0);
        din     = 26'd1024;
        din_vld = 1'b1;
        #2;
        ap_rst = 1'b1;
        #1;
        check("arst_din_rdy", din_rdy, 1);
        check("arst_dout_vld", dout_vld, 0);
        check("arst_dout", dout, 0);
        @(posedge ap_clk);
        #1;
        din_vld = 1'b0;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;
        drive_term(1024, 1);
        take_result("rst_mid", 1, 1'b0);

        repeat (3) @(posedge ap_clk);
        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
